// File: rtl/clk_en_rate_ctrl.sv
// Runtime rate selector for the shared clk_en_2/4/8/16 divider outputs.
// Rate changes are deferred to the common clk_en_16 boundary so en_out never shortens or doubles a period.
module clk_en_rate_ctrl #(
    parameter int unsigned RESET_RATE = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en_2,
    input  logic             clk_en_4,
    input  logic             clk_en_8,
    input  logic             clk_en_16,
    input  logic             cfg_valid,
    input  logic [2:0]       cfg_rate,
    output logic             cfg_ready,
    input  logic             sync_err_clr,
    output logic             en_out,
    output logic [2:0]       rate_cur,
    output logic             pending,
    output logic             cfg_err,
    output logic             sync_err,
    output logic [CNT_W-1:0] en_count
);

    localparam int unsigned RATE_W = 3;

    localparam logic [RATE_W-1:0] RATE_ALL  = RATE_W'(0);
    localparam logic [RATE_W-1:0] RATE_D2   = RATE_W'(1);
    localparam logic [RATE_W-1:0] RATE_D4   = RATE_W'(2);
    localparam logic [RATE_W-1:0] RATE_D8   = RATE_W'(3);
    localparam logic [RATE_W-1:0] RATE_D16  = RATE_W'(4);
    localparam logic [RATE_W-1:0] RATE_OFF  = RATE_W'(5);
    localparam logic [RATE_W-1:0] RATE_INIT = RATE_W'(RESET_RATE);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [RATE_W-1:0] rate_nxt;
    logic              apply_c;
    logic              phase_fault_c;

    // The apply edge is the first clk_en_16 cycle seen while a request is parked.
    assign apply_c = (state == ST_WAIT) && clk_en_16;

    // A faster enable must always be high whenever a slower one is.
    assign phase_fault_c = (clk_en_16 && !(clk_en_2 && clk_en_4 && clk_en_8))
                         || (clk_en_8 && !clk_en_4)
                         || (clk_en_4 && !clk_en_2);

    // Strobe mux; every non-off rate is high in the boundary cycle, which makes the switch seamless.
    always_comb begin
        en_out = 1'b0;
        case (rate_cur)
            RATE_ALL: en_out = 1'b1;
            RATE_D2:  en_out = clk_en_2;
            RATE_D4:  en_out = clk_en_4;
            RATE_D8:  en_out = clk_en_8;
            RATE_D16: en_out = clk_en_16;
            default:  en_out = 1'b0;
        endcase
    end

    // Request handshake and boundary-aligned apply.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cfg_ready <= 1'b1;
            pending   <= 1'b0;
            cfg_err   <= 1'b0;
            rate_cur  <= RATE_INIT;
            rate_nxt  <= RATE_INIT;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_rate <= RATE_OFF) begin
                            rate_nxt  <= cfg_rate;
                            state     <= ST_WAIT;
                            cfg_ready <= 1'b0;
                            pending   <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (clk_en_16) begin
                        rate_cur  <= rate_nxt;
                        state     <= ST_IDLE;
                        cfg_ready <= 1'b1;
                        pending   <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cfg_ready <= 1'b1;
                    pending   <= 1'b0;
                end
            endcase
        end
    end

    // Saturating strobe counter; the boundary strobe belongs to the old rate, so apply wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_count <= '0;
        end else if (apply_c) begin
            en_count <= '0;
        end else if (en_out && (en_count != CNT_MAX)) begin
            en_count <= en_count + CNT_W'(1);
        end
    end

    // Sticky phase error; a fresh fault beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_err <= 1'b0;
        end else if (phase_fault_c) begin
            sync_err <= 1'b1;
        end else if (sync_err_clr) begin
            sync_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_en_rate_ctrl.sv
// Bench for clk_en_rate_ctrl: models the clock_generator enables and scoreboards each accepted
// rate request against the rate and cycle at which it must take effect.
module tb_clk_en_rate_ctrl;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned SMALL_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               clk_en_2, clk_en_4, clk_en_8, clk_en_16;
    logic               cfg_valid = 1'b0;
    logic [2:0]         cfg_rate = 3'd0;
    logic               sync_err_clr = 1'b0;
    logic               cfg_ready, en_out, pending, cfg_err, sync_err;
    logic [2:0]         rate_cur;
    logic [CNT_W-1:0]   en_count;
    logic               cfg_ready_s, en_out_s, pending_s, cfg_err_s, sync_err_s;
    logic [2:0]         rate_cur_s;
    logic [SMALL_W-1:0] en_count_s;

    typedef struct {
        logic [2:0]  rate;
        int unsigned cycle;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    logic [3:0]  div_cnt;
    logic        force_e4_low = 1'b0;
    int          passed = 0;
    int          total = 0;

    clk_en_rate_ctrl #(.RESET_RATE(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .clk_en_2(clk_en_2), .clk_en_4(clk_en_4), .clk_en_8(clk_en_8), .clk_en_16(clk_en_16),
        .cfg_valid(cfg_valid), .cfg_rate(cfg_rate), .cfg_ready(cfg_ready),
        .sync_err_clr(sync_err_clr), .en_out(en_out), .rate_cur(rate_cur),
        .pending(pending), .cfg_err(cfg_err), .sync_err(sync_err), .en_count(en_count)
    );

    clk_en_rate_ctrl #(.RESET_RATE(5), .CNT_W(SMALL_W)) dut_small (
        .clk(clk), .rst(rst),
        .clk_en_2(clk_en_2), .clk_en_4(clk_en_4), .clk_en_8(clk_en_8), .clk_en_16(clk_en_16),
        .cfg_valid(cfg_valid), .cfg_rate(cfg_rate), .cfg_ready(cfg_ready_s),
        .sync_err_clr(sync_err_clr), .en_out(en_out_s), .rate_cur(rate_cur_s),
        .pending(pending_s), .cfg_err(cfg_err_s), .sync_err(sync_err_s), .en_count(en_count_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for clock_generator, held in reset together with the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst) div_cnt <= 4'd0;
        else      div_cnt <= div_cnt + 4'd1;
    end

    assign clk_en_2  = div_cnt[0];
    assign clk_en_4  = (div_cnt[1:0] == 2'b11) && !force_e4_low;
    assign clk_en_8  = (div_cnt[2:0] == 3'b111);
    assign clk_en_16 = (div_cnt == 4'd15);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_boundary();
        for (int i = 0; i < 16 && div_cnt != 4'd15; i++) tick();
    endtask

    // Offer a valid code for one edge and queue when and what it must apply.
    task automatic request(input logic [2:0] rate);
        exp_t        e;
        int unsigned w;
        if (div_cnt == 4'd15) w = 16;
        else                  w = 32'd15 - 32'(div_cnt);
        e.rate  = rate;
        e.cycle = cyc + w + 32'd1;
        sb.push_back(e);
        cfg_valid = 1'b1;
        cfg_rate  = rate;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Wait for pending to drop, then pop the oldest expectation and compare.
    task automatic drain_apply(input string name);
        exp_t e;
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (pending === 1'b0) seen = 1'b1;
        end
        if (!seen || sb.size() == 0) begin
            total++;
            $display("FAIL %s_apply: pending=%0b queued=%0d, required pending=0 with one queued", name, pending, sb.size());
        end else begin
            e = sb.pop_front();
            total++; if (rate_cur !== e.rate) $display("FAIL %s_rate: got %0d required %0d", name, rate_cur, e.rate); else passed++;
            total++; if (cyc !== e.cycle) $display("FAIL %s_latency: applied at cycle %0d required %0d", name, cyc, e.cycle); else passed++;
            total++; if (en_count !== '0) $display("FAIL %s_count_clr: got %0d required 0", name, en_count); else passed++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (en_out !== 1'b0) $display("FAIL reset_en_out: got %0b required 0", en_out); else passed++;
        end
        total++; if (rate_cur !== 3'd5) $display("FAIL reset_rate_cur: got %0d required 5", rate_cur); else passed++;
        total++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %0b required 1", cfg_ready); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL reset_pending: got %0b required 0", pending); else passed++;
        total++; if (en_count !== '0) $display("FAIL reset_en_count: got %0d required 0", en_count); else passed++;
        total++; if (cfg_err !== 1'b0 || sync_err !== 1'b0) $display("FAIL reset_errs: got cfg_err=%0b sync_err=%0b required 0/0", cfg_err, sync_err); else passed++;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++; if (en_out !== 1'b0) $display("FAIL off_en_out: got %0b required 0", en_out); else passed++;
        end
        total++; if (en_count !== '0) $display("FAIL off_en_count: got %0d required 0", en_count); else passed++;
    endtask

    task automatic test_apply_div4();
        wait_boundary();
        tick();
        tick();
        total++; if (cfg_ready !== 1'b1) $display("FAIL div4_ready: got %0b required 1", cfg_ready); else passed++;
        request(3'd2);
        total++; if (pending !== 1'b1 || cfg_ready !== 1'b0) $display("FAIL div4_wait: got pending=%0b ready=%0b required 1/0", pending, cfg_ready); else passed++;
        total++; if (rate_cur !== 3'd5) $display("FAIL div4_early: got %0d required 5", rate_cur); else passed++;
        drain_apply("div4");
        for (int i = 0; i < 16; i++) begin
            logic exp_en;
            exp_en = (div_cnt[1:0] == 2'b11);
            total++; if (en_out !== exp_en) $display("FAIL div4_en_out: got %0b required %0b at phase %0d", en_out, exp_en, div_cnt); else passed++;
            tick();
        end
        total++; if (en_count !== CNT_W'(4)) $display("FAIL div4_count: got %0d required 4", en_count); else passed++;
    endtask

    task automatic test_switch_every_cycle();
        int unsigned last;
        last = 0;
        request(3'd0);
        for (int i = 0; i < 16 && div_cnt != 4'd15; i++) begin
            if (en_out === 1'b1) last = cyc;
            tick();
        end
        total++; if (en_out !== 1'b1) $display("FAIL switch_boundary_en: got %0b required 1", en_out); else passed++;
        total++; if (cyc - last !== 32'd4) $display("FAIL switch_interval: got %0d required 4", cyc - last); else passed++;
        drain_apply("switch");
        for (int i = 0; i < 8; i++) begin
            total++; if (en_out !== 1'b1) $display("FAIL switch_en_out: got %0b required 1", en_out); else passed++;
            tick();
        end
        total++; if (en_count !== CNT_W'(8)) $display("FAIL switch_count: got %0d required 8", en_count); else passed++;
    endtask

    task automatic test_invalid_code();
        cfg_valid = 1'b1;
        cfg_rate  = 3'd6;
        tick();
        cfg_valid = 1'b0;
        total++; if (cfg_err !== 1'b1) $display("FAIL inv_cfg_err: got %0b required 1", cfg_err); else passed++;
        total++; if (cfg_ready !== 1'b1 || pending !== 1'b0) $display("FAIL inv_state: got ready=%0b pending=%0b required 1/0", cfg_ready, pending); else passed++;
        total++; if (rate_cur !== 3'd0) $display("FAIL inv_rate_cur: got %0d required 0", rate_cur); else passed++;
        tick();
        total++; if (cfg_err !== 1'b0) $display("FAIL inv_pulse_len: got %0b required 0", cfg_err); else passed++;
        wait_boundary();
        tick();
        request(3'd3);
        cfg_valid = 1'b1;
        cfg_rate  = 3'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (cfg_err !== 1'b0 || pending !== 1'b1) $display("FAIL inv_in_wait: got cfg_err=%0b pending=%0b required 0/1", cfg_err, pending); else passed++;
        end
        cfg_valid = 1'b0;
        drain_apply("inv_keep");
        for (int i = 0; i < 8; i++) begin
            logic exp_en;
            exp_en = (div_cnt[2:0] == 3'b111);
            total++; if (en_out !== exp_en) $display("FAIL div8_en_out: got %0b required %0b", en_out, exp_en); else passed++;
            tick();
        end
    endtask

    task automatic test_accept_on_boundary();
        wait_boundary();
        request(3'd4);
        total++; if (pending !== 1'b1) $display("FAIL bnd_pending: got %0b required 1", pending); else passed++;
        drain_apply("bnd");
        for (int i = 0; i < 16; i++) begin
            logic exp_en;
            exp_en = (div_cnt == 4'd15);
            total++; if (en_out !== exp_en) $display("FAIL div16_en_out: got %0b required %0b", en_out, exp_en); else passed++;
            tick();
        end
        total++; if (en_count !== CNT_W'(1)) $display("FAIL div16_count: got %0d required 1", en_count); else passed++;
    endtask

    task automatic test_sync_err();
        total++; if (sync_err !== 1'b0) $display("FAIL sync_idle: got %0b required 0", sync_err); else passed++;
        wait_boundary();
        force_e4_low = 1'b1;
        tick();
        force_e4_low = 1'b0;
        total++; if (sync_err !== 1'b1) $display("FAIL sync_set: got %0b required 1", sync_err); else passed++;
        repeat (3) tick();
        total++; if (sync_err !== 1'b1) $display("FAIL sync_sticky: got %0b required 1", sync_err); else passed++;
        sync_err_clr = 1'b1;
        tick();
        sync_err_clr = 1'b0;
        total++; if (sync_err !== 1'b0) $display("FAIL sync_clr: got %0b required 0", sync_err); else passed++;
        wait_boundary();
        force_e4_low = 1'b1;
        sync_err_clr = 1'b1;
        tick();
        force_e4_low = 1'b0;
        sync_err_clr = 1'b0;
        total++; if (sync_err !== 1'b1) $display("FAIL sync_set_wins: got %0b required 1", sync_err); else passed++;
        sync_err_clr = 1'b1;
        tick();
        sync_err_clr = 1'b0;
        total++; if (sync_err !== 1'b0) $display("FAIL sync_clr2: got %0b required 0", sync_err); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        wait_boundary();
        tick();
        request(3'd1);
        total++; if (pending !== 1'b1) $display("FAIL rstw_pending: got %0b required 1", pending); else passed++;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++; if (pending !== 1'b0 || cfg_ready !== 1'b1) $display("FAIL rstw_state: got pending=%0b ready=%0b required 0/1", pending, cfg_ready); else passed++;
        total++; if (rate_cur !== 3'd5) $display("FAIL rstw_rate: got %0d required 5", rate_cur); else passed++;
        total++; if (en_out !== 1'b0) $display("FAIL rstw_en_out: got %0b required 0", en_out); else passed++;
        sb.delete();
        tick();
        rst = 1'b1;
        repeat (20) tick();
        total++; if (rate_cur !== 3'd5 || pending !== 1'b0) $display("FAIL rstw_discard: got rate=%0d pending=%0b required 5/0", rate_cur, pending); else passed++;
    endtask

    task automatic test_saturation();
        request(3'd0);
        drain_apply("sat");
        total++; if (rate_cur_s !== 3'd0) $display("FAIL sat_small_rate: got %0d required 0", rate_cur_s); else passed++;
        repeat (15) tick();
        total++; if (en_count_s !== 4'd15) $display("FAIL sat_reach: got %0d required 15", en_count_s); else passed++;
        total++; if (en_count !== CNT_W'(15)) $display("FAIL sat_wide15: got %0d required 15", en_count); else passed++;
        repeat (5) tick();
        total++; if (en_count_s !== 4'd15) $display("FAIL sat_hold: got %0d required 15", en_count_s); else passed++;
        total++; if (en_count !== CNT_W'(20)) $display("FAIL sat_wide20: got %0d required 20", en_count); else passed++;
        request(3'd0);
        drain_apply("same_rate");
        total++; if (en_count_s !== 4'd0) $display("FAIL same_rate_small_clr: got %0d required 0", en_count_s); else passed++;
    endtask

    initial begin
        test_reset();
        test_apply_div4();
        test_switch_every_cycle();
        test_invalid_code();
        test_accept_on_boundary();
        test_sync_err();
        test_reset_mid_wait();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
